// File: rtl/key_debounce_conditioner_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : key_cond_pkg
//  Brief    : Shared constants and sizing helpers for the key conditioner.
//  Revision : 1.0
// ============================================================================
package key_cond_pkg;

    localparam logic KEY_RELEASED = 1'b1;

    function automatic int calc_stable_cycles(input int clk_hz, input int debounce_ms);
        return (clk_hz / 1000) * debounce_ms;
    endfunction

    function automatic int cnt_width(input int stable);
        return (stable < 1) ? 1 : $clog2(stable + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce_conditioner_if
//  Brief    : Raw key inputs and conditioned key outputs as one bundle.
//  Revision : 1.0
// ============================================================================
interface key_debounce_conditioner_if #(
    parameter int NUM_KEYS = 4
);
    logic [NUM_KEYS-1:0] key_n_raw;
    logic [NUM_KEYS-1:0] key_export;
    logic [NUM_KEYS-1:0] key_pressed;
    logic [NUM_KEYS-1:0] key_released;
    logic                key_any;

    modport master (
        output key_n_raw,
        input  key_export,
        input  key_pressed,
        input  key_released,
        input  key_any
    );

    modport slave (
        input  key_n_raw,
        output key_export,
        output key_pressed,
        output key_released,
        output key_any
    );
endinterface
`default_nettype wire

// File: rtl/key_debounce_conditioner_channel.sv
`default_nettype none
// ============================================================================
//  Module   : debounce_channel
//  Brief    : One key: synchroniser, stability counter, level and edge pulses.
//  Revision : 1.0
// ============================================================================
module debounce_channel
    import key_cond_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int CNT_W         = 3
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_key_n,
    output logic      o_state,
    output logic      o_state_nxt,
    output logic      o_pressed,
    output logic      o_released
);

    // One capture flop ahead of the synchroniser proper, so a new level
    // reaches key_export SYNC_STAGES + STABLE_CYCLES edges after capture.
    localparam int               c_CHAIN    = SYNC_STAGES + 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic [c_CHAIN-1:0] r_sync;
    logic               r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_pressed;
    logic               r_released;

    logic               w_sync;
    logic               w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               w_pressed_nxt;
    logic               w_released_nxt;

    assign w_sync = r_sync[c_CHAIN-1];

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = '0;
        w_pressed_nxt  = 1'b0;
        w_released_nxt = 1'b0;
        if (w_sync != r_state) begin
            if (r_cnt == c_CNT_LAST) begin
                w_state_nxt    = w_sync;
                w_pressed_nxt  = (w_sync != KEY_RELEASED);
                w_released_nxt = (w_sync == KEY_RELEASED);
            end else begin
                w_cnt_nxt = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync     <= '1;
            r_state    <= KEY_RELEASED;
            r_cnt      <= '0;
            r_pressed  <= 1'b0;
            r_released <= 1'b0;
        end else begin
            r_sync     <= {r_sync[c_CHAIN-2:0], i_key_n};
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pressed  <= w_pressed_nxt;
            r_released <= w_released_nxt;
        end
    end

    assign o_state     = r_state;
    assign o_state_nxt = w_state_nxt;
    assign o_pressed   = r_pressed;
    assign o_released  = r_released;

endmodule
`default_nettype wire

// File: rtl/key_debounce_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : key_debounce_conditioner
//  Brief    : Debounces NUM_KEYS active-low buttons for the key PIO.
//  Revision : 1.0
// ============================================================================
module key_debounce_conditioner
    import key_cond_pkg::*;
#(
    parameter int NUM_KEYS    = 4,
    parameter int CLK_HZ      = 50000000,
    parameter int DEBOUNCE_MS = 10,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic                   clk_clk,
    input  wire logic                   reset_reset,
    key_debounce_conditioner_if.slave   bus
);

    localparam int c_STABLE_CYCLES = calc_stable_cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int c_CNT_W         = cnt_width(c_STABLE_CYCLES);

    logic [NUM_KEYS-1:0] w_state_nxt;
    logic                r_key_any;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
            debounce_channel #(
                .STABLE_CYCLES (c_STABLE_CYCLES),
                .SYNC_STAGES   (SYNC_STAGES),
                .CNT_W         (c_CNT_W)
            ) u_chan (
                .clk         (clk_clk),
                .rst         (reset_reset),
                .i_key_n     (bus.key_n_raw[gi]),
                .o_state     (bus.key_export[gi]),
                .o_state_nxt (w_state_nxt[gi]),
                .o_pressed   (bus.key_pressed[gi]),
                .o_released  (bus.key_released[gi])
            );
        end
    endgenerate

    // Built from next-state so it moves on the same edge as key_export.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            r_key_any <= 1'b0;
        end else begin
            r_key_any <= |(~w_state_nxt);
        end
    end

    assign bus.key_any = r_key_any;

endmodule
`default_nettype wire

// File: tb/tb_key_debounce_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_debounce_conditioner
//  Brief    : Scoreboard bench with a history-based reference model.
//  Revision : 1.0
// ============================================================================
module tb_key_debounce_conditioner;

    localparam int NK     = 4;
    localparam int SC     = 4;        // stable cycles for CLK_HZ=1000, 4 ms
    localparam int D      = 3;        // raw sample to debouncer view delay
    localparam int MAXE   = 8000;

    typedef struct packed {
        logic [NK-1:0] exp;
        logic [NK-1:0] pr;
        logic [NK-1:0] rl;
        logic          any;
    } exp_t;

    logic clk_clk     = 1'b0;
    logic reset_reset = 1'b1;

    key_debounce_conditioner_if #(.NUM_KEYS(NK)) bus ();

    key_debounce_conditioner #(
        .NUM_KEYS    (NK),
        .CLK_HZ      (1000),
        .DEBOUNCE_MS (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .bus         (bus)
    );

    always #5 clk_clk = ~clk_clk;

    exp_t          sb_q[$];
    int            checks = 0;
    int            errors = 0;
    logic [NK-1:0] raw_hist [0:MAXE-1];
    int            n        = 0;
    int            last_rst = 0;
    int            last_ev [NK];
    logic [NK-1:0] m_state  = '1;

    // Expected outputs after edge n: a key flips once the last SC samples it
    // saw (raw delayed by D, forced released right after reset) all differ
    // from its level, with none of them older than its previous flip/reset.
    task automatic model_step(input logic [NK-1:0] raw, input logic rst);
        exp_t e;
        logic ok;
        logic o;
        e.pr = '0;
        e.rl = '0;
        raw_hist[n] = raw;
        if (rst) begin
            m_state  = '1;
            last_rst = n;
            for (int k = 0; k < NK; k++) last_ev[k] = n;
        end else begin
            for (int k = 0; k < NK; k++) begin
                ok = 1'b1;
                for (int j = n - SC + 1; j <= n; j++) begin
                    if (j <= last_ev[k]) begin
                        ok = 1'b0;
                    end else begin
                        o = (j - D > last_rst) ? raw_hist[j-D][k] : 1'b1;
                        if (o == m_state[k]) ok = 1'b0;
                    end
                end
                if (ok) begin
                    m_state[k] = ~m_state[k];
                    if (m_state[k] == 1'b0) e.pr[k] = 1'b1;
                    else                    e.rl[k] = 1'b1;
                    last_ev[k] = n;
                end
            end
        end
        e.exp = m_state;
        e.any = |(~m_state);
        sb_q.push_back(e);
    endtask

    task automatic cyc(input logic [NK-1:0] raw, input logic rst);
        @(negedge clk_clk);
        bus.key_n_raw = raw;
        reset_reset   = rst;
        @(posedge clk_clk);
        #1;
        model_step(raw, rst);
        n++;
    endtask

    task automatic hold(input logic [NK-1:0] raw, input int cycles);
        for (int i = 0; i < cycles; i++) cyc(raw, 1'b0);
    endtask

    task automatic chk(input string name, input logic [NK-1:0] act, input logic [NK-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %b expected %b", name, n, act, req);
        end
    endtask

    // Monitor: one expected record per modelled edge, compared mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("key_export",   bus.key_export,   e.exp);
                chk("key_pressed",  bus.key_pressed,  e.pr);
                chk("key_released", bus.key_released, e.rl);
                chk("key_any",      {3'b000, bus.key_any}, {3'b000, e.any});
            end
        end
    end

    initial begin
        logic [NK-1:0] cur;
        int            hcnt [NK];
        bus.key_n_raw = '1;

        // Reset with all keys released
        for (int i = 0; i < 3; i++) cyc(4'b1111, 1'b1);
        hold(4'b1111, 4);
        // Single key press and release
        hold(4'b1110, 9);
        hold(4'b1111, 9);
        // Bouncing key 1 before settling low
        for (int r = 0; r < 2; r++) begin
            hold(4'b1101, 3);
            hold(4'b1111, 1);
        end
        hold(4'b1101, 10);
        hold(4'b1111, 10);
        // Glitch boundary on key 2
        hold(4'b1011, 3);
        hold(4'b1111, 10);
        hold(4'b1011, 4);
        hold(4'b1111, 12);
        // Simultaneous release of key 3 and press of key 2
        hold(4'b0111, 10);
        hold(4'b1011, 10);
        hold(4'b1111, 10);
        // Reset in the middle of a debounce
        hold(4'b1110, 5);
        cyc(4'b1110, 1'b1);
        cyc(4'b1110, 1'b1);
        hold(4'b1110, 10);
        hold(4'b1111, 10);

        // Randomised bouncing on all keys with occasional resets
        cur = '1;
        for (int k = 0; k < NK; k++) hcnt[k] = $urandom_range(1, 9);
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < NK; k++) begin
                if (hcnt[k] == 0) begin
                    cur[k]  = ~cur[k];
                    hcnt[k] = $urandom_range(1, 9);
                end else begin
                    hcnt[k]--;
                end
            end
            cyc(cur, ($urandom_range(0, 199) == 0));
        end

        @(negedge clk_clk);
        @(negedge clk_clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d records left, expected 0", sb_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
